spi_master_ctl: RTL

SPI bus engine directly downstream of the Wishbone register slave. It consumes the slave's SPI write-data word, transfer-start bit and 2-bit device select. It shifts one 32-bit full-duplex SPI mode-0 frame to one of four chip selects. It returns the received word and a done flag, which the slave exposes for software polling.

---
 rtl/spi_master_ctl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctl.sv
// SPI mode-0 master: one 32-bit full-duplex frame per start edge, four chip selects.
// Define SPI_LSB_FIRST_EN to shift bit 0 first on both MOSI and MISO.
module spi_master_ctl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] SPI_DAT_I,
  input  logic        SPI_START_I,
  input  logic [1:0]  SPI_SEL_I,
  output logic [31:0] SPI_DAT_O,
  output logic        SPI_DONE_O,
  output logic        SPI_BUSY_O,
  output logic        SPI_SCLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic [3:0]  SPI_CS_N
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] SET_LAST = 8'(CS_SETUP - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  cs_n_q, cs_n_d;
  logic        start_q, start_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        launch;
  logic        div_end;

  assign launch  = SPI_START_I & ~start_q
                 & (state_q == S_IDLE);
  assign div_end = (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dat_d   = dat_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = done_q;
    busy_d  = busy_q;
    start_d = SPI_START_I;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_SETUP;
          cnt_d   = 8'd0;
          bit_d   = 6'd0;
          tx_d    = SPI_DAT_I;
          cs_n_d  = ~(4'b0001 << SPI_SEL_I);
          sclk_d  = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef SPI_LSB_FIRST_EN
          mosi_d  = SPI_DAT_I[0];
`else
          mosi_d  = SPI_DAT_I[31];
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == SET_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          cnt_d  = 8'd0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
`ifdef SPI_LSB_FIRST_EN
            rx_d = {SPI_MISO, rx_q[31:1]};
`else
            rx_d = {rx_q[30:0], SPI_MISO};
`endif
          end else if (bit_q == 6'd31) begin
            state_d = S_HOLD;
          end else begin
            bit_d = bit_q + 6'd1;
`ifdef SPI_LSB_FIRST_EN
            tx_d   = {1'b0, tx_q[31:1]};
            mosi_d = tx_q[1];
`else
            tx_d   = {tx_q[30:0], 1'b0};
            mosi_d = tx_q[30];
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (div_end) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          cs_n_d  = 4'hF;
          mosi_d  = 1'b0;
          dat_d   = rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // start_q resets high so a level held through reset cannot launch
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 6'd0;
      tx_q    <= 32'd0;
      rx_q    <= 32'd0;
      dat_q   <= 32'd0;
      cs_n_q  <= 4'hF;
      start_q <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dat_q   <= dat_d;
      cs_n_q  <= cs_n_d;
      start_q <= start_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign SPI_DAT_O  = dat_q;
  assign SPI_DONE_O = done_q;
  assign SPI_BUSY_O = busy_q;
  assign SPI_SCLK   = sclk_q;
  assign SPI_MOSI   = mosi_q;
  assign SPI_CS_N   = cs_n_q;

endmodule
